// File: rtl/acc_mem_pkg.sv
// Shared types and default widths for the CPU/accelerator memory arbiter.
// The FSM states and requester IDs live here so the top and the selector agree on encodings.
package acc_mem_pkg;

    localparam int DEF_ADDR_SIZE    = 16;
    localparam int DEF_RD_DATA_SIZE = 512;
    localparam int DEF_WR_DATA_SIZE = 32;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [2:0] {
        IDLE,
        CPU_XFER,
        ACC_RD_XFER,
        ACC_WR_XFER,
        DONE
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_CPU,
        REQ_ACC_RD,
        REQ_ACC_WR
    } req_id_e;

endpackage

// File: rtl/acc_arb_select.sv
// Requester priority select with an anti-starvation counter; combinational grant, 0 cycles.
// No backpressure of its own: a grant is only offered while arb_en_i (arbiter idle) is high.
module acc_arb_select
    import acc_mem_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    arb_en_i,
    input  logic    cpu_req_i,
    input  logic    rd_en_i,
    input  logic    wr_en_i,
    output logic    grant_vld_o,
    output req_id_e grant_id_o
);

    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             acc_pend;

    assign acc_pend = rd_en_i | wr_en_i;

    always_comb begin
        grant_vld_o = 1'b0;
        grant_id_o  = REQ_CPU;
        if (starve_cnt_q == CNT_MAX && acc_pend) begin
            grant_vld_o = 1'b1;
            grant_id_o  = rd_en_i ? REQ_ACC_RD : REQ_ACC_WR;
        end else if (cpu_req_i) begin
            grant_vld_o = 1'b1;
            grant_id_o  = REQ_CPU;
        end else if (rd_en_i) begin
            grant_vld_o = 1'b1;
            grant_id_o  = REQ_ACC_RD;
        end else if (wr_en_i) begin
            grant_vld_o = 1'b1;
            grant_id_o  = REQ_ACC_WR;
        end
        if (!arb_en_i) begin
            grant_vld_o = 1'b0;
        end
    end

    // Only CPU wins that overtake a waiting accelerator count toward starvation.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_vld_o) begin
            if (grant_id_o == REQ_CPU) begin
                if (acc_pend && starve_cnt_q != CNT_MAX) begin
                    starve_cnt_d = starve_cnt_q + CNT_W'(1);
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/acc_mem_arbiter.sv
// Arbitrates one memory port between a CPU and an accelerator (read/write); grant to done pulse >= 2 cycles.
// Requests are levels held until done; the memory stalls a transfer by withholding mem_ack.
module acc_mem_arbiter
    import acc_mem_pkg::*;
#(
    parameter int ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int RD_DATA_SIZE = DEF_RD_DATA_SIZE,
    parameter int WR_DATA_SIZE = DEF_WR_DATA_SIZE,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic                    cpu_we,
    input  logic [ADDR_SIZE-1:0]    cpu_addr,
    input  logic [WR_DATA_SIZE-1:0] cpu_wdata,
    output logic                    cpu_done,
    output logic [RD_DATA_SIZE-1:0] cpu_rdata,
    input  logic                    mem_acc_read_en,
    input  logic [ADDR_SIZE-1:0]    mem_acc_read_addr,
    output logic [RD_DATA_SIZE-1:0] mem_acc_read_data,
    output logic                    mem_acc_read_data_valid,
    input  logic                    mem_acc_write_en,
    input  logic [ADDR_SIZE-1:0]    mem_acc_write_addr,
    input  logic [WR_DATA_SIZE-1:0] mem_acc_write_data,
    output logic                    mem_acc_write_done,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_SIZE-1:0]    mem_addr,
    output logic [WR_DATA_SIZE-1:0] mem_wdata,
    input  logic [RD_DATA_SIZE-1:0] mem_rdata,
    input  logic                    mem_ack,
    output logic                    arb_busy
);

    arb_state_e              state_q;
    req_id_e                 owner_q;
    logic                    mem_en_q;
    logic                    mem_we_q;
    logic [ADDR_SIZE-1:0]    addr_q;
    logic [WR_DATA_SIZE-1:0] wdata_q;
    logic [RD_DATA_SIZE-1:0] cpu_rdata_q;
    logic [RD_DATA_SIZE-1:0] acc_rdata_q;
    logic                    cpu_done_q;
    logic                    rd_vld_q;
    logic                    wr_done_q;

    logic    grant_vld;
    req_id_e grant_id;

    acc_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_sel (
        .clk         (clk),
        .rst_n       (rst_n),
        .arb_en_i    (state_q == IDLE),
        .cpu_req_i   (cpu_req),
        .rd_en_i     (mem_acc_read_en),
        .wr_en_i     (mem_acc_write_en),
        .grant_vld_o (grant_vld),
        .grant_id_o  (grant_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= REQ_CPU;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            acc_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            cpu_done_q <= 1'b0;
            rd_vld_q   <= 1'b0;
            wr_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        owner_q  <= grant_id;
                        mem_en_q <= 1'b1;
                        case (grant_id)
                            REQ_CPU: begin
                                mem_we_q <= cpu_we;
                                addr_q   <= cpu_addr;
                                wdata_q  <= cpu_wdata;
                                state_q  <= CPU_XFER;
                            end
                            REQ_ACC_RD: begin
                                mem_we_q <= 1'b0;
                                addr_q   <= mem_acc_read_addr;
                                state_q  <= ACC_RD_XFER;
                            end
                            default: begin
                                mem_we_q <= 1'b1;
                                addr_q   <= mem_acc_write_addr;
                                wdata_q  <= mem_acc_write_data;
                                state_q  <= ACC_WR_XFER;
                            end
                        endcase
                    end
                end
                CPU_XFER, ACC_RD_XFER, ACC_WR_XFER: begin
                    if (mem_ack) begin
                        mem_en_q <= 1'b0;
                        state_q  <= DONE;
                        case (owner_q)
                            REQ_CPU: begin
                                cpu_done_q <= 1'b1;
                                // A CPU write must not disturb the last read line.
                                if (!mem_we_q) begin
                                    cpu_rdata_q <= mem_rdata;
                                end
                            end
                            REQ_ACC_RD: begin
                                rd_vld_q    <= 1'b1;
                                acc_rdata_q <= mem_rdata;
                            end
                            default: begin
                                wr_done_q <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_en                  = mem_en_q;
    assign mem_we                  = mem_we_q;
    assign mem_addr                = addr_q;
    assign mem_wdata               = wdata_q;
    assign cpu_done                = cpu_done_q;
    assign cpu_rdata               = cpu_rdata_q;
    assign mem_acc_read_data       = acc_rdata_q;
    assign mem_acc_read_data_valid = rd_vld_q;
    assign mem_acc_write_done      = wr_done_q;
    assign arb_busy                = (state_q != IDLE);

endmodule
